// File: rtl/linescanner_pkg.sv
// Shared types and constants for the line scanner packing path.
package linescanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DROP,
        ST_CLOSE
    } state_t;

    localparam int PIXEL_W         = 8;
    localparam int PIXELS_PER_WORD = 4;
    localparam int WORD_W          = 32;
    localparam int KEEP_W          = 4;
    localparam int USER_W          = 2;
    localparam int ENTRY_W         = WORD_W + KEEP_W + USER_W + 1;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } entry_t;

    // Byte-lane mask for a word holding n pixels (n = 1..3; 0 is never requested).
    function automatic logic [KEEP_W-1:0] lane_mask(input logic [1:0] n);
        return (4'b0001 << n) - 4'b0001;
    endfunction

endpackage

// File: rtl/linescanner_sync_fifo.sv
// First-word-fall-through FIFO: array storage with a registered read stage that feeds the output.
module linescanner_sync_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      mem_count_reg;
    logic [AW:0]      mem_count_next;
    logic [AW:0]      total_count;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             pop;
    logic             push;
    logic             load;

    // The output register counts as a slot, so capacity is exactly DEPTH words.
    assign total_count = mem_count_reg + {{AW{1'b0}}, out_valid_reg};
    assign full        = (total_count == (AW+1)'(DEPTH));
    assign pop         = out_valid_reg && rd_en;
    assign push        = wr_en && (!full || pop);
    assign load        = (mem_count_reg != '0) && (!out_valid_reg || pop);

    assign rd_data  = out_data_reg;
    assign rd_valid = out_valid_reg;

    always_comb begin
        mem_count_next = mem_count_reg;
        case ({push, load})
            2'b10:   mem_count_next = mem_count_reg + (AW+1)'(1);
            2'b01:   mem_count_next = mem_count_reg - (AW+1)'(1);
            default: mem_count_next = mem_count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_count_reg <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            mem_count_reg <= mem_count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (load) begin
                rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                out_data_reg  <= mem[rd_ptr_reg];
                out_valid_reg <= 1'b1;
            end else if (pop) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/linescanner_line_packer.sv
// Packs LVAL-qualified 8-bit pixels into 32-bit words per line, tags the last word and
// buffers the result in an FWFT FIFO feeding a valid/ready stream.
module linescanner_line_packer
    import linescanner_pkg::*;
#(
    parameter int LINE_PIXELS = 1024,
    parameter int FIFO_DEPTH  = 512
) (
    input  logic                pixel_clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [PIXEL_W-1:0]  pixel_data,
    input  logic                pixel_captured,
    output logic [WORD_W-1:0]   m_data,
    output logic [KEEP_W-1:0]   m_keep,
    output logic [USER_W-1:0]   m_user,
    output logic                m_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                line_done,
    output logic [15:0]         line_length,
    output logic [15:0]         line_count
);
    localparam logic [16:0] LINE_PIXELS_C = 17'(LINE_PIXELS);

    state_t            state_reg, state_next;
    logic [16:0]       count_reg, count_next;
    logic [16:0]       count_inc;
    logic [WORD_W-1:0] word_reg, word_next;
    logic [WORD_W-1:0] stage_data_reg, stage_data_next;
    logic              stage_valid_reg, stage_valid_next;
    logic              truncated_reg, truncated_next;
    logic              overflow_reg, overflow_next;
    logic              line_done_reg, line_done_next;
    logic [15:0]       line_length_reg, line_length_next;
    logic [15:0]       line_count_reg, line_count_next;

    logic [1:0]        lane;
    logic              packable;
    logic [1:0]        packed_lanes;
    logic [WORD_W-1:0] packed_word;
    logic              sample;
    logic              can_push;
    logic              fifo_push;
    logic              fifo_full;
    entry_t            fifo_wr_entry;
    entry_t            fifo_rd_entry;

    assign lane         = count_reg[1:0];
    assign packable     = count_reg < LINE_PIXELS_C;
    assign packed_lanes = packable ? count_reg[1:0] : LINE_PIXELS_C[1:0];
    assign count_inc    = (count_reg == 17'h1FFFF) ? count_reg : count_reg + 17'd1;
    assign sample       = pixel_captured && (state_reg == ST_ARM || state_reg == ST_CAPTURE);
    // A full FIFO still takes a word when the consumer pops in the same cycle.
    assign can_push     = !fifo_full || (m_valid && m_ready);

    genvar gi;
    generate
        for (gi = 0; gi < PIXELS_PER_WORD; gi++) begin : g_lane
            assign packed_word[gi*PIXEL_W +: PIXEL_W] =
                (lane == 2'(gi)) ? pixel_data : word_reg[gi*PIXEL_W +: PIXEL_W];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        word_next        = word_reg;
        stage_data_next  = stage_data_reg;
        stage_valid_next = stage_valid_reg;
        truncated_next   = truncated_reg;
        overflow_next    = overflow_reg;
        line_done_next   = 1'b0;
        line_length_next = line_length_reg;
        line_count_next  = line_count_reg;
        fifo_push        = 1'b0;
        fifo_wr_entry    = '0;

        case (state_reg)
            ST_IDLE: begin
                if (enable && !pixel_captured) begin
                    state_next       = ST_ARM;
                    count_next       = '0;
                    word_next        = '0;
                    stage_valid_next = 1'b0;
                    truncated_next   = 1'b0;
                    overflow_next    = 1'b0;
                end
            end
            ST_ARM: begin
                if (pixel_captured) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!pixel_captured) begin
                    state_next = ST_CLOSE;
                end
            end
            ST_DROP: begin
                if (pixel_captured) begin
                    count_next = count_inc;
                end else begin
                    state_next = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (can_push) begin
                    fifo_push          = 1'b1;
                    fifo_wr_entry.last = 1'b1;
                    fifo_wr_entry.user = {truncated_reg, overflow_reg};
                    if (overflow_reg) begin
                        fifo_wr_entry.data = '0;
                        fifo_wr_entry.keep = '0;
                    end else if (stage_valid_reg) begin
                        fifo_wr_entry.data = stage_data_reg;
                        fifo_wr_entry.keep = '1;
                    end else begin
                        fifo_wr_entry.data = word_reg;
                        fifo_wr_entry.keep = lane_mask(packed_lanes);
                    end
                    stage_valid_next = 1'b0;
                    line_done_next   = 1'b1;
                    line_length_next = count_reg[16] ? 16'hFFFF : count_reg[15:0];
                    line_count_next  = line_count_reg + 16'd1;
                    state_next       = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The staged word leaves only when a further packed pixel proves it is not the last.
        if (sample) begin
            count_next = count_inc;
            if (!packable) begin
                truncated_next = 1'b1;
            end else if (stage_valid_reg && !can_push) begin
                overflow_next    = 1'b1;
                stage_valid_next = 1'b0;
                state_next       = ST_DROP;
            end else begin
                if (stage_valid_reg) begin
                    fifo_push          = 1'b1;
                    fifo_wr_entry.data = stage_data_reg;
                    fifo_wr_entry.keep = '1;
                    stage_valid_next   = 1'b0;
                end
                if (lane == 2'd3) begin
                    stage_data_next  = packed_word;
                    stage_valid_next = 1'b1;
                    word_next        = '0;
                end else begin
                    word_next = packed_word;
                end
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            word_reg        <= '0;
            stage_data_reg  <= '0;
            stage_valid_reg <= 1'b0;
            truncated_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
            line_done_reg   <= 1'b0;
            line_length_reg <= '0;
            line_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            word_reg        <= word_next;
            stage_data_reg  <= stage_data_next;
            stage_valid_reg <= stage_valid_next;
            truncated_reg   <= truncated_next;
            overflow_reg    <= overflow_next;
            line_done_reg   <= line_done_next;
            line_length_reg <= line_length_next;
            line_count_reg  <= line_count_next;
        end
    end

    linescanner_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (pixel_clock),
        .srst     (reset),
        .wr_en    (fifo_push),
        .wr_data  (fifo_wr_entry),
        .full     (fifo_full),
        .rd_en    (m_ready),
        .rd_data  (fifo_rd_entry),
        .rd_valid (m_valid)
    );

    assign m_data      = fifo_rd_entry.data;
    assign m_keep      = fifo_rd_entry.keep;
    assign m_user      = fifo_rd_entry.user;
    assign m_last      = fifo_rd_entry.last;
    assign line_done   = line_done_reg;
    assign line_length = line_length_reg;
    assign line_count  = line_count_reg;

endmodule

// File: tb/tb_linescanner_line_packer.sv
// Drives one pixel stream into three packer configurations (default, short line limit,
// shallow FIFO) and checks every accepted word and line report against a per-line model.
module tb_linescanner_line_packer;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  pixel_data;
    logic        pixel_captured;
    logic        m_ready;

    logic [31:0] m_data_a, m_data_t, m_data_o;
    logic [3:0]  m_keep_a, m_keep_t, m_keep_o;
    logic [1:0]  m_user_a, m_user_t, m_user_o;
    logic        m_last_a, m_last_t, m_last_o;
    logic        m_valid_a, m_valid_t, m_valid_o;
    logic        line_done_a, line_done_t, line_done_o;
    logic [15:0] line_length_a, line_length_t, line_length_o;
    logic [15:0] line_count_a, line_count_t, line_count_o;

    int total = 0;
    int bad   = 0;

    logic [38:0] exp_q0[$], exp_q1[$], exp_q2[$];
    logic [38:0] log_q0[$], log_q1[$], log_q2[$];
    int          len_q0[$], len_q1[$], len_q2[$];
    int          ll_log2[$];
    logic [15:0] exp_cnt [3];
    bit          hold_prev [3];
    logic [38:0] prev_word [3];

    always #5 pixel_clock = ~pixel_clock;

    linescanner_line_packer #(.LINE_PIXELS(1024), .FIFO_DEPTH(512)) dut_a (
        .pixel_clock(pixel_clock), .reset(reset), .enable(enable), .pixel_data(pixel_data),
        .pixel_captured(pixel_captured), .m_data(m_data_a), .m_keep(m_keep_a), .m_user(m_user_a),
        .m_last(m_last_a), .m_valid(m_valid_a), .m_ready(m_ready), .line_done(line_done_a),
        .line_length(line_length_a), .line_count(line_count_a));

    linescanner_line_packer #(.LINE_PIXELS(8), .FIFO_DEPTH(512)) dut_t (
        .pixel_clock(pixel_clock), .reset(reset), .enable(enable), .pixel_data(pixel_data),
        .pixel_captured(pixel_captured), .m_data(m_data_t), .m_keep(m_keep_t), .m_user(m_user_t),
        .m_last(m_last_t), .m_valid(m_valid_t), .m_ready(m_ready), .line_done(line_done_t),
        .line_length(line_length_t), .line_count(line_count_t));

    linescanner_line_packer #(.LINE_PIXELS(1024), .FIFO_DEPTH(4)) dut_o (
        .pixel_clock(pixel_clock), .reset(reset), .enable(enable), .pixel_data(pixel_data),
        .pixel_captured(pixel_captured), .m_data(m_data_o), .m_keep(m_keep_o), .m_user(m_user_o),
        .m_last(m_last_o), .m_valid(m_valid_o), .m_ready(m_ready), .line_done(line_done_o),
        .line_length(line_length_o), .line_count(line_count_o));

    task automatic chk(input string name, input int inst, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h", name, inst, got, want);
        end
    endtask

    task automatic push_exp(input int inst, input logic [38:0] e);
        case (inst)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic push_len(input int inst, input int len);
        case (inst)
            0:       len_q0.push_back(len);
            1:       len_q1.push_back(len);
            default: len_q2.push_back(len);
        endcase
    endtask

    task automatic pop_exp(input int inst, output bit have, output logic [38:0] e);
        have = 1'b0;
        e    = '0;
        case (inst)
            0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
        endcase
    endtask

    task automatic pop_len(input int inst, output bit have, output int len);
        have = 1'b0;
        len  = 0;
        case (inst)
            0:       if (len_q0.size() > 0) begin len = len_q0.pop_front(); have = 1'b1; end
            1:       if (len_q1.size() > 0) begin len = len_q1.pop_front(); have = 1'b1; end
            default: if (len_q2.size() > 0) begin len = len_q2.pop_front(); have = 1'b1; end
        endcase
    endtask

    // Line-level model: chop the accepted pixels into groups of four; a stalled shallow
    // FIFO keeps only its first cap words and ends the line with an empty flagged word.
    task automatic model_line(input int inst, input int n, input logic [7:0] base, input bit stalled);
        int          lp, cap, packed_n, nwords, idx;
        bit          trunc, ovf;
        logic [31:0] d;
        logic [3:0]  k;
        lp       = (inst == 1) ? 8 : 1024;
        cap      = (inst == 2) ? 4 : 512;
        packed_n = (n < lp) ? n : lp;
        trunc    = (n > lp);
        nwords   = (packed_n + 3) / 4;
        ovf      = stalled && (packed_n > 4 * cap + 4);
        for (int w = 0; w < (ovf ? cap : nwords); w++) begin
            d = '0;
            k = '0;
            for (int i = 0; i < 4; i++) begin
                idx = 4 * w + i;
                if (idx < packed_n) begin
                    d[8*i +: 8] = base + 8'(idx);
                    k[i]        = 1'b1;
                end
            end
            if (!ovf && w == nwords - 1) push_exp(inst, {d, k, trunc, 1'b0, 1'b1});
            else                         push_exp(inst, {d, k, 2'b00, 1'b0});
        end
        if (ovf) push_exp(inst, {32'h0, 4'h0, trunc, 1'b1, 1'b1});
        push_len(inst, (n > 65535) ? 65535 : n);
    endtask

    task automatic clear_model();
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        len_q0.delete(); len_q1.delete(); len_q2.delete();
        for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
    endtask

    task automatic check_port(input int inst, input logic v, input logic [31:0] d, input logic [3:0] k,
                              input logic [1:0] u, input logic l, input logic ld,
                              input logic [15:0] llen, input logic [15:0] lcnt);
        logic [38:0] got, want;
        bit          have;
        int          len;
        got = {d, k, u, l};
        if (hold_prev[inst]) begin
            chk("hold_valid", inst, 64'(v), 64'(1'b1));
            chk("hold_word", inst, 64'(got), 64'(prev_word[inst]));
        end
        hold_prev[inst] = v && !m_ready;
        prev_word[inst] = got;
        if (v && !l) chk("user_nonlast", inst, 64'(u), 64'(0));
        if (v && m_ready) begin
            pop_exp(inst, have, want);
            $display("inst%0d word data=%h keep=%h user=%b last=%b", inst, d, k, u, l);
            case (inst)
                0:       log_q0.push_back(got);
                1:       log_q1.push_back(got);
                default: log_q2.push_back(got);
            endcase
            if (!have) chk("unexpected_word", inst, 64'(got), 64'(0));
            else       chk("word", inst, 64'(got), 64'(want));
        end
        if (ld) begin
            pop_len(inst, have, len);
            exp_cnt[inst] = exp_cnt[inst] + 16'd1;
            if (inst == 2) ll_log2.push_back(int'(llen));
            chk("line_done_expected", inst, 64'(have), 64'(1'b1));
            chk("line_length", inst, 64'(llen), 64'(len));
            chk("line_count", inst, 64'(lcnt), 64'(exp_cnt[inst]));
        end
    endtask

    always @(negedge pixel_clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) hold_prev[i] = 1'b0;
        end else begin
            check_port(0, m_valid_a, m_data_a, m_keep_a, m_user_a, m_last_a, line_done_a, line_length_a, line_count_a);
            check_port(1, m_valid_t, m_data_t, m_keep_t, m_user_t, m_last_t, line_done_t, line_length_t, line_count_t);
            check_port(2, m_valid_o, m_data_o, m_keep_o, m_user_o, m_last_o, line_done_o, line_length_o, line_count_o);
        end
    end

    task automatic check_reset_state(input bit full_set);
        chk("rst_valid", 0, 64'(m_valid_a), 64'(0));
        chk("rst_valid", 1, 64'(m_valid_t), 64'(0));
        chk("rst_valid", 2, 64'(m_valid_o), 64'(0));
        chk("rst_count", 0, 64'(line_count_a), 64'(0));
        chk("rst_count", 1, 64'(line_count_t), 64'(0));
        chk("rst_count", 2, 64'(line_count_o), 64'(0));
        chk("rst_length", 0, 64'(line_length_a), 64'(0));
        chk("rst_length", 1, 64'(line_length_t), 64'(0));
        chk("rst_length", 2, 64'(line_length_o), 64'(0));
        if (full_set) begin
            chk("rst_done", 0, 64'(line_done_a), 64'(0));
            chk("rst_data", 0, 64'({m_data_a, m_keep_a, m_user_a, m_last_a}), 64'(0));
            chk("rst_data", 2, 64'({m_data_o, m_keep_o, m_user_o, m_last_o}), 64'(0));
        end
    endtask

    task automatic send_line(input int n, input logic [7:0] base, input bit expect_it, input bit stalled,
                             input int en_at, input bit en_val, input int rst_at);
        if (expect_it) begin
            for (int inst = 0; inst < 3; inst++) model_line(inst, n, base, stalled);
        end
        for (int i = 0; i < n; i++) begin
            if (i == en_at) enable = en_val;
            pixel_captured = 1'b1;
            pixel_data     = base + 8'(i);
            if (i == rst_at) begin
                reset = 1'b1;
                clear_model();
            end
            @(posedge pixel_clock);
            #1;
            if (i == rst_at) begin
                reset = 1'b0;
                @(negedge pixel_clock);
                check_reset_state(1'b0);
            end
        end
        pixel_captured = 1'b0;
        pixel_data     = '0;
        repeat (4) begin
            @(posedge pixel_clock);
            #1;
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && exp_q2.size() == 0 &&
                len_q0.size() == 0 && len_q1.size() == 0 && len_q2.size() == 0) begin
                done = 1'b1;
            end else begin
                @(posedge pixel_clock);
                #1;
            end
        end
        chk("drain", 0, 64'(exp_q0.size() + exp_q1.size() + exp_q2.size() +
                            len_q0.size() + len_q1.size() + len_q2.size()), 64'(0));
        repeat (3) begin
            @(posedge pixel_clock);
            #1;
        end
    endtask

    task automatic pin(input string name, input int inst, input int idx, input logic [38:0] want);
        logic [38:0] got;
        int          sz;
        sz  = (inst == 0) ? log_q0.size() : (inst == 1) ? log_q1.size() : log_q2.size();
        got = '0;
        if (idx < sz) got = (inst == 0) ? log_q0[idx] : (inst == 1) ? log_q1[idx] : log_q2[idx];
        chk({name, "_present"}, inst, 64'(idx < sz), 64'(1'b1));
        chk(name, inst, 64'(got), 64'(want));
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        pixel_data     = '0;
        pixel_captured = 1'b0;
        m_ready        = 1'b1;
        clear_model();
        repeat (3) @(posedge pixel_clock);
        #1;
        reset = 1'b0;
        @(negedge pixel_clock);
        check_reset_state(1'b1);

        enable = 1'b1;
        repeat (3) begin
            @(posedge pixel_clock);
            #1;
        end

        send_line(8,  8'h01, 1'b1, 1'b0, -1, 1'b0, -1);
        send_line(6,  8'hA0, 1'b1, 1'b0, -1, 1'b0, -1);
        send_line(11, 8'h30, 1'b1, 1'b0, -1, 1'b0, -1);
        wait_drain();

        // Stalled consumer; enable drops during the line so every packer parks in IDLE.
        m_ready = 1'b0;
        send_line(40, 8'h40, 1'b1, 1'b1, 39, 1'b0, -1);
        repeat (10) begin
            @(posedge pixel_clock);
            #1;
        end
        m_ready = 1'b1;
        wait_drain();

        // enable rises mid-line: that line must be skipped.
        send_line(5, 8'h60, 1'b0, 1'b0, 2, 1'b1, -1);
        send_line(6, 8'h70, 1'b1, 1'b0, -1, 1'b0, -1);
        wait_drain();

        send_line(10, 8'h80, 1'b0, 1'b0, -1, 1'b0, 5);
        send_line(7,  8'h90, 1'b1, 1'b0, -1, 1'b0, -1);
        wait_drain();

        pin("t1_w0",    0, 0,  {32'h04030201, 4'hF, 2'b00, 1'b0});
        pin("t1_w1",    0, 1,  {32'h08070605, 4'hF, 2'b00, 1'b1});
        pin("t2_w0",    0, 2,  {32'hA3A2A1A0, 4'hF, 2'b00, 1'b0});
        pin("t2_w1",    0, 3,  {32'h0000A5A4, 4'h3, 2'b00, 1'b1});
        pin("t3_last",  1, 5,  {32'h37363534, 4'hF, 2'b10, 1'b1});
        pin("t4_first", 2, 7,  {32'h43424140, 4'hF, 2'b00, 1'b0});
        pin("t4_ovf",   2, 11, {32'h00000000, 4'h0, 2'b01, 1'b1});
        pin("t5_w0",    0, 17, {32'h73727170, 4'hF, 2'b00, 1'b0});
        pin("t6_w0",    0, 19, {32'h93929190, 4'hF, 2'b00, 1'b0});
        pin("t6_w1",    0, 20, {32'h00969594, 4'h7, 2'b00, 1'b1});
        chk("t4_len_present", 2, 64'(ll_log2.size() > 3), 64'(1'b1));
        if (ll_log2.size() > 3) chk("t4_len", 2, 64'(ll_log2[3]), 64'(40));
        chk("final_count", 0, 64'(line_count_a), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
